// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a synchronous instruction RAM with one-cycle read latency.
// Three stages: F (address out), D (RAM data returning), O (registered instruction).
module inst_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [31:0]       Redirect_PC,
  output logic [ADDR_W-1:0] Ram_Addr,
  input  logic [31:0]       Ram_Dout,
  output logic [31:0]       Inst_Code,
  output logic [31:0]       Inst_PC,
  output logic              Inst_Valid,
  output logic [31:0]       Fetch_Cnt
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] inst_code_q, inst_code_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        hold;
  logic        accept;

  assign hold   = Stall & inst_valid_q;
  assign accept = inst_valid_q & ~Stall;

  // Replaying PC_D while held keeps Ram_Dout pointing at the instruction behind the stall.
  assign Ram_Addr = hold ? pc_d_q[ADDR_W+1:2] : pc_f_q[ADDR_W+1:2];

  always_comb begin
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    d_valid_d    = d_valid_q;
    inst_code_d  = inst_code_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (Redirect) begin
      pc_f_d       = {Redirect_PC[31:2], 2'b00};
      d_valid_d    = 1'b0;
      inst_valid_d = 1'b0;
    end else if (!hold) begin
      pc_f_d       = pc_f_q + 32'd4;
      pc_d_d       = pc_f_q;
      d_valid_d    = 1'b1;
      inst_code_d  = Ram_Dout;
      inst_pc_d    = pc_d_q;
      inst_valid_d = d_valid_q;
    end
  end

  // Counting is independent of redirect: an accepted instruction still counts.
  assign fetch_cnt_d = accept ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_f_q       <= RESET_PC;
      pc_d_q       <= 32'd0;
      d_valid_q    <= 1'b0;
      inst_code_q  <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= 32'd0;
    end else begin
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      d_valid_q    <= d_valid_d;
      inst_code_q  <= inst_code_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign Inst_Code  = inst_code_q;
  assign Inst_PC    = inst_pc_q;
  assign Inst_Valid = inst_valid_q;
  assign Fetch_Cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: vector table for the main run plus a
// hand-written mid-cycle reset sequence.
module tb_inst_fetch_ctrl;

  localparam int unsigned ADDR_W = 6;

  logic              Clk;
  logic              Rst;
  logic              Stall;
  logic              Redirect;
  logic [31:0]       Redirect_PC;
  logic [ADDR_W-1:0] Ram_Addr;
  logic [31:0]       Ram_Dout;
  logic [31:0]       Inst_Code;
  logic [31:0]       Inst_PC;
  logic              Inst_Valid;
  logic [31:0]       Fetch_Cnt;

  int checks = 0;
  int errors = 0;

  inst_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Ram_Addr    (Ram_Addr),
    .Ram_Dout    (Ram_Dout),
    .Inst_Code   (Inst_Code),
    .Inst_PC     (Inst_PC),
    .Inst_Valid  (Inst_Valid),
    .Fetch_Cnt   (Fetch_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: mem[i] = 32'h1000_0000 + i, one-cycle read latency.
  always @(posedge Clk) Ram_Dout <= 32'h1000_0000 + {26'd0, Ram_Addr};

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [5:0]  addr;   // expected Ram_Addr before the edge
    logic        valid;  // expected outputs after the edge
    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic [5:0] addr, input logic v, input logic [31:0] pc,
                     input logic [31:0] code, input logic [31:0] cnt);
    vec_t e;
    e = '{stall: st, redir: rd, rpc: rpc, addr: addr, valid: v, pc: pc, code: code, cnt: cnt};
    tbl.push_back(e);
  endtask

  initial begin
    Rst = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    Redirect_PC = 32'd0;

    //  st  rd  rpc            addr v  pc             code            cnt
    add(0, 0, 32'h0,          0,  0, 32'h0,         32'h0,          0);  // fill
    add(0, 0, 32'h0,          1,  1, 32'h0,         32'h1000_0000,  0);  // first valid
    add(0, 0, 32'h0,          2,  1, 32'h4,         32'h1000_0001,  1);
    add(0, 0, 32'h0,          3,  1, 32'h8,         32'h1000_0002,  2);
    add(1, 0, 32'h0,          3,  1, 32'h8,         32'h1000_0002,  2);  // stall x3
    add(1, 0, 32'h0,          3,  1, 32'h8,         32'h1000_0002,  2);
    add(1, 0, 32'h0,          3,  1, 32'h8,         32'h1000_0002,  2);
    add(0, 0, 32'h0,          4,  1, 32'hC,         32'h1000_0003,  3);
    add(0, 0, 32'h0,          5,  1, 32'h10,        32'h1000_0004,  4);
    add(0, 1, 32'h26,         6,  0, 32'h0,         32'h0,          5);  // redirect
    add(0, 0, 32'h0,          9,  0, 32'h0,         32'h0,          5);
    add(0, 0, 32'h0,          10, 1, 32'h24,        32'h1000_0009,  5);
    add(0, 0, 32'h0,          11, 1, 32'h28,        32'h1000_000A,  6);
    add(1, 0, 32'h0,          11, 1, 32'h28,        32'h1000_000A,  6);  // held
    add(1, 1, 32'hF8,         11, 0, 32'h0,         32'h0,          6);  // redirect drops held
    add(1, 0, 32'h0,          62, 0, 32'h0,         32'h0,          6);  // stall w/o valid
    add(0, 0, 32'h0,          63, 1, 32'hF8,        32'h1000_003E,  6);
    add(0, 0, 32'h0,          0,  1, 32'hFC,        32'h1000_003F,  7);
    add(0, 0, 32'h0,          1,  1, 32'h100,       32'h1000_0000,  8);  // alias
    add(0, 1, 32'hFFFF_FFFC,  2,  0, 32'h0,         32'h0,          9);
    add(0, 0, 32'h0,          63, 0, 32'h0,         32'h0,          9);
    add(0, 0, 32'h0,          0,  1, 32'hFFFF_FFFC, 32'h1000_003F,  9);  // PC wrap
    add(0, 0, 32'h0,          1,  1, 32'h0,         32'h1000_0000,  10);
    add(0, 1, 32'h40,         2,  0, 32'h0,         32'h0,          11); // back-to-back
    add(0, 1, 32'h80,         16, 0, 32'h0,         32'h0,          11);
    add(0, 0, 32'h0,          32, 0, 32'h0,         32'h0,          11);
    add(0, 0, 32'h0,          33, 1, 32'h80,        32'h1000_0020,  11);

    #3;
    chk("rst_valid", {31'd0, Inst_Valid}, 32'd0);
    chk("rst_code", Inst_Code, 32'd0);
    chk("rst_pc", Inst_PC, 32'd0);
    chk("rst_cnt", Fetch_Cnt, 32'd0);
    chk("rst_addr", {26'd0, Ram_Addr}, 32'd0);

    @(negedge Clk);
    Rst = 1'b1;
    foreach (tbl[i]) begin
      Stall = tbl[i].stall;
      Redirect = tbl[i].redir;
      Redirect_PC = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_addr", i), {26'd0, Ram_Addr}, {26'd0, tbl[i].addr});
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, Inst_Valid}, {31'd0, tbl[i].valid});
      chk($sformatf("v%0d_cnt", i), Fetch_Cnt, tbl[i].cnt);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_pc", i), Inst_PC, tbl[i].pc);
        chk($sformatf("v%0d_code", i), Inst_Code, tbl[i].code);
      end
      if (i != tbl.size() - 1) @(negedge Clk);
    end

    // Asynchronous reset in the middle of a cycle.
    Stall = 1'b0;
    Redirect = 1'b0;
    #1;
    Rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, Inst_Valid}, 32'd0);
    chk("mid_rst_code", Inst_Code, 32'd0);
    chk("mid_rst_pc", Inst_PC, 32'd0);
    chk("mid_rst_cnt", Fetch_Cnt, 32'd0);
    chk("mid_rst_addr", {26'd0, Ram_Addr}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("restart_e1_valid", {31'd0, Inst_Valid}, 32'd0);
    @(posedge Clk);
    #1;
    chk("restart_e2_valid", {31'd0, Inst_Valid}, 32'd1);
    chk("restart_e2_pc", Inst_PC, 32'h0);
    chk("restart_e2_code", Inst_Code, 32'h1000_0000);
    chk("restart_e2_cnt", Fetch_Cnt, 32'd0);
    @(posedge Clk);
    #1;
    chk("restart_e3_pc", Inst_PC, 32'h4);
    chk("restart_e3_code", Inst_Code, 32'h1000_0001);
    chk("restart_e3_cnt", Fetch_Cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
